conv_dnn_bridge: RTL

Elastic, frame-aware buffer between the conv/pooling output stage and the DNN input stage.
- Absorbs conv output beats: per-kernel valid vector, NumPE data lanes, set-done marker.
- Replays the beats to the DNN under a downstream ready handshake.
- Counts completed images and emits a frame-done pulse.
- Drains and isolates frames, so the chain runs continuously without a reset after every NumOfK images.

---
 rtl/conv_dnn_bridge_pkg.sv | 31 +++
 rtl/bridge_fifo.sv | 69 ++++++
 rtl/conv_dnn_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_dnn_bridge_pkg.sv
// Shared types and sizing constants for the conv -> DNN bridge.
package conv_dnn_bridge_pkg;

  localparam int unsigned BIT_SIZE      = 32;
  localparam int unsigned NUM_PE        = 2;
  localparam int unsigned NUM_OF_K      = 4;
  localparam int unsigned DEPTH         = 8;
  localparam int unsigned READY_MARGIN  = 2;
  localparam int unsigned NUM_OF_IMAGES = 4;

  localparam int unsigned DATA_W = NUM_PE * BIT_SIZE;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned IMG_W  = $clog2(NUM_OF_IMAGES + 1);
  localparam int unsigned BEAT_W = 16;

  // Lane 0 sits in the least significant BIT_SIZE bits.
  typedef logic [NUM_PE-1:0][BIT_SIZE-1:0] lanes_t;

  typedef struct packed {
    logic [NUM_OF_K-1:0] valid;
    lanes_t              lanes;
    logic                set_done;
  } entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/bridge_fifo.sv
// Generic synchronous FIFO. Callers pass only legal wr_en/rd_en; the
// next-cycle head and occupancy are exported so the owner can register
// its outputs straight from the entry that will be at the head.
module bridge_fifo #(
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 8,
  localparam int unsigned PTR_W  = $clog2(Depth),
  localparam int unsigned CNT_W  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  entry_t           wr_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output entry_t           head_nxt_c,
  output logic             empty_nxt_c,
  output logic [CNT_W-1:0] count_nxt_c
);

  entry_t           mem [Depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // Next occupancy, read pointer and head entry.
  always_comb begin
    count_nxt_c = count;
    rd_ptr_nxt  = rd_ptr;
    case ({wr_en, rd_en})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
    if (rd_en) rd_ptr_nxt = rd_ptr + PTR_W'(1);
    empty_nxt_c = (count_nxt_c == '0);
    // The incoming entry becomes head when nothing else remains after the pop.
    if (wr_en && ((count == '0) || ((count == CNT_W'(1)) && rd_en))) begin
      head_nxt_c = wr_entry;
    end else begin
      head_nxt_c = mem[rd_ptr_nxt];
    end
  end

  // Storage array; contents need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt_c;
      full   <= (count_nxt_c == CNT_W'(Depth));
      empty  <= empty_nxt_c;
    end
  end

endmodule

// File: rtl/conv_dnn_bridge.sv
// Elastic, frame-aware buffer between the conv output stage and the DNN
// input stage. Counts set-done markers leaving the buffer, pulses
// out_frame_done per completed frame and stops upstream until the buffer
// drains. Define CONV_DNN_BRIDGE_STATS_EN to enable the popped-beat counter.
module conv_dnn_bridge
  import conv_dnn_bridge_pkg::*;
(
  input  logic                       clk,
  input  logic                       res_n,
  input  logic [NUM_OF_K-1:0]        in_valid,
  input  logic [NUM_PE*BIT_SIZE-1:0] in_data,
  input  logic                       in_set_done,
  output logic                       out_ready,
  input  logic                       dn_ready,
  output logic [NUM_OF_K-1:0]        out_valid,
  output logic [NUM_PE*BIT_SIZE-1:0] out_data,
  output logic                       out_set_done,
  output logic                       out_frame_done,
  output logic                       out_overflow,
  output logic [BEAT_W-1:0]          out_beat_count
);

  logic             push_req_c;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic             ovf_set_c;
  entry_t           wr_entry_c;
  entry_t           head_nxt_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic             empty_nxt_c;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_nxt_c;

  state_t           state;
  state_t           state_nxt;
  logic [IMG_W-1:0] img_cnt;
  logic [IMG_W-1:0] img_cnt_nxt;
  logic             frame_done_nxt;
  logic             ready_nxt;

  // Handshake decode; a full buffer still takes a beat when it pops.
  always_comb begin
    push_req_c          = (|in_valid) | in_set_done;
    pop_ok_c            = !fifo_empty & dn_ready;
    push_ok_c           = push_req_c & (!fifo_full | pop_ok_c);
    ovf_set_c           = push_req_c & fifo_full & !pop_ok_c;
    wr_entry_c.valid    = in_valid;
    wr_entry_c.lanes    = lanes_t'(in_data);
    wr_entry_c.set_done = in_set_done;
  end

  bridge_fifo #(
    .entry_t (entry_t),
    .Depth   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .res_n       (res_n),
    .wr_en       (push_ok_c),
    .rd_en       (pop_ok_c),
    .wr_entry    (wr_entry_c),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .head_nxt_c  (head_nxt_c),
    .empty_nxt_c (empty_nxt_c),
    .count_nxt_c (count_nxt_c)
  );

  // Frame tracking: out_set_done mirrors the head marker whenever non-empty.
  always_comb begin
    state_nxt      = state;
    img_cnt_nxt    = img_cnt;
    frame_done_nxt = 1'b0;
    if (pop_ok_c && out_set_done) begin
      if (img_cnt == IMG_W'(NUM_OF_IMAGES - 1)) begin
        img_cnt_nxt    = '0;
        frame_done_nxt = 1'b1;
        state_nxt      = DRAIN;
      end else begin
        img_cnt_nxt = img_cnt + IMG_W'(1);
      end
    end else if ((state == DRAIN) && (fifo_count == '0)) begin
      state_nxt = RUN;
    end
    ready_nxt = (state_nxt == RUN) && (count_nxt_c <= CNT_W'(DEPTH - READY_MARGIN));
  end

  // Frame state register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= RUN;
      img_cnt <= '0;
    end else begin
      state   <= state_nxt;
      img_cnt <= img_cnt_nxt;
    end
  end

  // Registered outputs, loaded from the entry that will be at the head.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_valid      <= '0;
      out_data       <= '0;
      out_set_done   <= 1'b0;
      out_frame_done <= 1'b0;
      out_overflow   <= 1'b0;
      out_ready      <= 1'b0;
    end else begin
      out_valid      <= empty_nxt_c ? '0 : head_nxt_c.valid;
      out_set_done   <= !empty_nxt_c & head_nxt_c.set_done;
      if (!empty_nxt_c) out_data <= head_nxt_c.lanes;
      out_frame_done <= frame_done_nxt;
      out_overflow   <= out_overflow | ovf_set_c;
      out_ready      <= ready_nxt;
    end
  end

`ifdef CONV_DNN_BRIDGE_STATS_EN
  // Saturating count of popped entries.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_beat_count <= '0;
    end else if (pop_ok_c && (out_beat_count != {BEAT_W{1'b1}})) begin
      out_beat_count <= out_beat_count + BEAT_W'(1);
    end
  end
`else
  assign out_beat_count = '0;
`endif

endmodule
